// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its request front end.
// Holds the request FSM encoding and a counter sizing helper.
package traffic_pkg;

   localparam int unsigned CLK_HZ = 125_000_000;

   typedef enum logic [1:0] {
      REQ_IDLE    = 2'd0,
      REQ_PENDING = 2'd1,
      REQ_SERVING = 2'd2,
      REQ_LOCKOUT = 2'd3
   } req_state_t;

   // Counter width for a modulus, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crossing_request_unit_debouncer.sv
// Two-flop synchroniser plus debounce counter for the raw push-button.
// Emits a one-cycle pulse on each rising edge of the debounced level.
module button_debouncer
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic stable,
   output logic press_pulse
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_stable;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_flip;

   assign w_diff = r_s2 ^ r_stable;
   assign w_flip = w_diff & (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_pulse  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1    <= btn_raw;
         r_s2    <= r_s1;
         r_pulse <= w_flip & r_s2;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign stable      = r_stable;
   assign press_pulse = r_pulse;

endmodule

// File: rtl/crossing_request_unit.sv
// Pedestrian/side-road request front end: debounced press in, request and
// WAIT lamp out, with a lockout window after each cross-road green.
module crossing_request_unit
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
   parameter int unsigned LOCKOUT_CYCLES  = 250_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       cg_in,
   output logic       req,
   output logic       wait_lamp,
   output logic       press_pulse,
   output logic [7:0] press_count
);

   localparam int unsigned LW = cnt_width(LOCKOUT_CYCLES);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

   logic          w_stable;
   logic          w_pulse;
   logic          w_press;
   logic          w_cg_rise;
   logic          w_cg_fall;
   logic          r_cg_q;
   req_state_t    r_state;
   req_state_t    w_next;
   logic [LW-1:0] r_lock_cnt;
   logic          r_req;
   logic          r_wait;
   logic [7:0]    r_count;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .stable     (w_stable),
      .press_pulse(w_pulse)
   );

   // The pulse is registered alongside the level flip, so both agree
   assign w_press   = w_pulse & w_stable;
   assign w_cg_rise = cg_in & ~r_cg_q;
   assign w_cg_fall = ~cg_in & r_cg_q;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         REQ_IDLE: begin
            if (w_press) w_next = cg_in ? REQ_SERVING : REQ_PENDING;
         end
         REQ_PENDING: begin
            if (w_cg_rise) w_next = REQ_SERVING;
         end
         REQ_SERVING: begin
            if (w_cg_fall) w_next = REQ_LOCKOUT;
         end
         REQ_LOCKOUT: begin
            if (w_cg_rise) w_next = REQ_SERVING;
            else if (r_lock_cnt == '0) w_next = REQ_IDLE;
         end
         default: w_next = REQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cg_q     <= 1'b0;
         r_state    <= REQ_IDLE;
         r_lock_cnt <= '0;
         r_req      <= 1'b0;
         r_wait     <= 1'b0;
         r_count    <= 8'h00;
      end else begin
         r_cg_q  <= cg_in;
         r_state <= w_next;
         r_req   <= (w_next == REQ_PENDING);
         r_wait  <= (w_next == REQ_PENDING) | (w_next == REQ_SERVING);
         if ((r_state == REQ_SERVING) && w_cg_fall)
            r_lock_cnt <= LOCK_LOAD;
         else if ((r_state == REQ_LOCKOUT) && (r_lock_cnt != '0))
            r_lock_cnt <= r_lock_cnt - 1'b1;
         if (w_pulse && (r_count != 8'hFF))
            r_count <= r_count + 8'h01;
      end
   end

   assign req         = r_req;
   assign wait_lamp   = r_wait;
   assign press_pulse = w_pulse;
   assign press_count = r_count;

endmodule

// File: tb/tb_crossing_request_unit.sv
// Randomised and directed bench for crossing_request_unit against a
// behavioural model built from debounce-history and request-phase rules.
module tb_crossing_request_unit;

   localparam int D = 4;
   localparam int L = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_raw = 1'b0;
   logic       cg_in = 1'b0;
   logic       req;
   logic       wait_lamp;
   logic       press_pulse;
   logic [7:0] press_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   crossing_request_unit #(
      .DEBOUNCE_CYCLES(D),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .cg_in      (cg_in),
      .req        (req),
      .wait_lamp  (wait_lamp),
      .press_pulse(press_pulse),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   // Behavioural model
   bit m_s1, m_s2, m_stable, m_pulse, m_cgprev;
   bit m_pending, m_serving;
   int m_lock_left;
   int m_cnt;
   bit hist[$];

   always @(posedge clk) begin
      bit rise, fall, all_diff, np;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_pulse = 0; m_cgprev = 0;
         m_pending = 0; m_serving = 0; m_lock_left = 0; m_cnt = 0;
         hist.delete();
      end else begin
         rise = cg_in && !m_cgprev;
         fall = !cg_in && m_cgprev;
         if (m_lock_left > 0) begin
            if (rise) begin
               m_lock_left = 0;
               m_serving = 1;
            end else begin
               m_lock_left--;
            end
         end else if (m_serving) begin
            if (fall) begin
               m_serving = 0;
               m_lock_left = L;
            end
         end else if (m_pending) begin
            if (rise) begin
               m_pending = 0;
               m_serving = 1;
            end
         end else if (m_pulse) begin
            if (cg_in) m_serving = 1;
            else m_pending = 1;
         end
         m_cgprev = cg_in;
         if (m_pulse && m_cnt < 255) m_cnt++;
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         all_diff = (hist.size() == D);
         foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
         np = 0;
         if (all_diff) begin
            m_stable = m_s2;
            np = m_s2;
         end
         m_pulse = np;
         m_s2 = m_s1;
         m_s1 = btn_raw;
      end
      #1;
      chk("press_pulse", int'(press_pulse), int'(m_pulse));
      chk("req", int'(req), int'(m_pending));
      chk("wait_lamp", int'(wait_lamp), int'(m_pending | m_serving));
      chk("press_count", int'(press_count), m_cnt);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press();
      btn_raw = 1'b1;
      tick(7);
      btn_raw = 1'b0;
      tick(7);
   endtask

   // Waits for press_pulse and checks it lands 1+D edges after first sample
   task automatic wait_pulse(input string name, input int n0);
      bit seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(posedge clk);
         #2;
         if (press_pulse) begin
            seen = 1;
            chk(name, cyc, n0 + 1 + D);
         end
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int n0;
      @(negedge clk);
      tick(3);
      chk("reset_req", int'(req), 0);
      chk("reset_wait", int'(wait_lamp), 0);
      chk("reset_count", int'(press_count), 0);
      reset = 1'b0;
      tick(3);

      // Bounce then steady press
      btn_raw = 1; tick(1);
      btn_raw = 0; tick(1);
      btn_raw = 1; tick(1);
      btn_raw = 0; tick(1);
      btn_raw = 1;
      n0 = cyc + 1;
      wait_pulse("bounce_latency", n0);
      tick(3);
      chk("bounce_count", int'(press_count), 1);
      chk("bounce_req", int'(req), 1);
      btn_raw = 0;
      tick(10);

      // Handshake, presses while serving and in lockout
      cg_in = 1; tick(1);
      chk("grant_req", int'(req), 0);
      chk("grant_wait", int'(wait_lamp), 1);
      tick(2);
      press();
      chk("serving_req", int'(req), 0);
      chk("serving_wait", int'(wait_lamp), 1);
      cg_in = 0; tick(1);
      chk("lockout_wait", int'(wait_lamp), 0);
      btn_raw = 1; tick(7);
      btn_raw = 0;
      chk("lockout_req", int'(req), 0);
      chk("lockout_count", int'(press_count), 3);
      tick(10);
      press();
      chk("after_lock_req", int'(req), 1);
      cg_in = 1; tick(3);
      cg_in = 0; tick(12);

      // Already green
      cg_in = 1; tick(2);
      press();
      chk("green_req", int'(req), 0);
      chk("green_wait", int'(wait_lamp), 1);
      tick(3);
      cg_in = 0; tick(1);
      chk("green_wait_off", int'(wait_lamp), 0);
      tick(12);

      // Reset mid-operation with button held
      press();
      chk("pre_reset_req", int'(req), 1);
      btn_raw = 1; tick(2);
      reset = 1; tick(1);
      reset = 0;
      chk("post_reset_req", int'(req), 0);
      chk("post_reset_wait", int'(wait_lamp), 0);
      chk("post_reset_count", int'(press_count), 0);
      n0 = cyc + 1;
      wait_pulse("reset_latency", n0);
      btn_raw = 0;
      tick(10);

      // Random segments
      for (int s = 0; s < 200; s++) begin
         btn_raw = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) cg_in = ~cg_in;
         reset = ($urandom_range(0, 59) == 0);
         tick($urandom_range(1, 9));
         reset = 0;
      end
      btn_raw = 0; cg_in = 0;
      tick(20);

      // Saturation
      reset = 1; tick(1);
      reset = 0;
      for (int p = 0; p < 260; p++) begin
         btn_raw = 1; tick(6);
         btn_raw = 0; tick(6);
      end
      chk("saturate", int'(press_count), 255);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
